// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART blocks of cpu_top.
//   - tx_state_t : transmitter frame state
//   - UART_DATA / UART_STAT : MMIO addresses decoded by the CPU store path
//   - calc_div   : clocks per bit for a given core clock and line rate
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam logic [31:0] UART_DATA = 32'h1000_0000;
   localparam logic [31:0] UART_STAT = 32'h1000_0004;

   // Integer clocks per bit; the caller guarantees the ratio is >= 2.
   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO. pop_data always shows the head
//   entry. Pushes while full and pops while empty are ignored, so callers may
//   drive push/pop unconditionally.
// Ports
//   clk, rstn   : clock, asynchronous active-low reset (pointers only)
//   push        : write push_data when not full
//   pop         : discard head entry when not empty
//   pop_data    : head entry (valid when empty = 0)
//   full, empty : occupancy flags, decoded from registered pointers
//   level       : occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
   localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
   localparam logic [AW:0] PTR_ZERO   = (AW+1)'(0);

   // Pointers carry one extra MSB so full and empty differ when indices match.
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             push_ok_s;
   logic             pop_ok_s;

   assign level     = wr_ptr_r - rd_ptr_r;
   assign full      = (level == FULL_LEVEL);
   assign empty     = (level == PTR_ZERO);
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

   // Pointer registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
//   Buffered 8N1 UART transmitter. CPU stores arrive as one-cycle wr_en pulses,
//   are queued in a sync_fifo and sent LSB-first at CLK_HZ/BAUD clocks per bit.
//   Writes while full are dropped and latch the sticky overflow flag.
// Ports
//   clk, rstn : core clock, asynchronous active-low reset
//   wr_en     : write strobe, wr_data : byte to send
//   full      : FIFO holds FIFO_DEPTH bytes
//   busy      : frame in progress or bytes queued
//   level     : FIFO occupancy
//   overflow  : sticky, a write was dropped (cleared by reset only)
//   uart_tx   : registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          wr_en,
   input  logic [7:0]                    wr_data,
   output logic                          full,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic                          uart_tx
);

   localparam int DIV = calc_div(CLK_HZ, BAUD);
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

   tx_state_t   state_r;
   tx_state_t   state_next_s;
   logic [CW-1:0] baud_cnt_r;
   logic [2:0]  bit_idx_r;
   logic [7:0]  shift_r;
   logic [7:0]  shift_next_s;
   logic        uart_tx_r;
   logic        tx_next_s;
   logic        overflow_r;
   logic        fifo_empty_s;
   logic [7:0]  fifo_data_s;
   logic        pop_s;
   logic        baud_wrap_s;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (pop_s),
      .pop_data  (fifo_data_s),
      .full      (full),
      .empty     (fifo_empty_s),
      .level     (level)
   );

   assign baud_wrap_s = (baud_cnt_r == BAUD_LAST);
   // Pop when leaving IDLE or at the end of STOP, giving zero-gap frames.
   assign pop_s    = ~fifo_empty_s &
                     ((state_r == IDLE) | ((state_r == STOP) & baud_wrap_s));
   assign busy     = (state_r != IDLE) | ~fifo_empty_s;
   assign overflow = overflow_r;
   assign uart_tx  = uart_tx_r;

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (!fifo_empty_s) state_next_s = START;
            else               state_next_s = IDLE;
         end
         START: begin
            if (baud_wrap_s) state_next_s = DATA;
            else             state_next_s = START;
         end
         DATA: begin
            if (baud_wrap_s && (bit_idx_r == 3'd7)) state_next_s = STOP;
            else                                     state_next_s = DATA;
         end
         STOP: begin
            if (baud_wrap_s) state_next_s = fifo_empty_s ? IDLE : START;
            else             state_next_s = STOP;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Output decode: line level for the state being entered, so uart_tx is registered.
   always_comb begin
      tx_next_s = 1'b1;
      case (state_next_s)
         IDLE:    tx_next_s = 1'b1;
         START:   tx_next_s = 1'b0;
         DATA:    tx_next_s = shift_next_s[0];
         STOP:    tx_next_s = 1'b1;
         default: tx_next_s = 1'b1;
      endcase
   end

   // Shift register next value: load on pop, shift right after each data bit.
   always_comb begin
      shift_next_s = shift_r;
      if (pop_s) begin
         shift_next_s = fifo_data_s;
      end else if ((state_r == DATA) && baud_wrap_s) begin
         shift_next_s = {1'b0, shift_r[7:1]};
      end else begin
         shift_next_s = shift_r;
      end
   end

   // Datapath registers: baud counter, bit index, shift register, line, overflow.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         baud_cnt_r <= CNT_ZERO;
         bit_idx_r  <= 3'd0;
         shift_r    <= 8'd0;
         uart_tx_r  <= 1'b1;
         overflow_r <= 1'b0;
      end else begin
         if ((state_r == IDLE) || baud_wrap_s) begin
            baud_cnt_r <= CNT_ZERO;
         end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
         end
         // 3-bit index wraps 7 -> 0 on the last data bit, ready for the next frame.
         if ((state_r == DATA) && baud_wrap_s) begin
            bit_idx_r <= bit_idx_r + 3'd1;
         end
         shift_r   <= shift_next_s;
         uart_tx_r <= tx_next_s;
         if (wr_en && full) begin
            overflow_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
//   Scoreboard bench: accepted bytes are queued when written and compared with
//   the bytes reconstructed from uart_tx by a serial receiver model.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

   localparam int DIV = 10;

   logic       clk = 1'b0;
   logic       rstn;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       busy;
   logic [2:0] level;
   logic       overflow;
   logic       uart_tx;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   // Receiver model state.
   logic       rx_active = 1'b0;
   int         rx_cnt    = 0;
   logic [7:0] rx_sh     = 8'd0;
   int         rx_frames = 0;

   uart_tx_buffered #(
      .CLK_HZ     (1000),
      .BAUD       (100),
      .FIFO_DEPTH (4)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .busy     (busy),
      .level    (level),
      .overflow (overflow),
      .uart_tx  (uart_tx)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Receiver model: samples mid-bit on the falling clock edge.
   always @(negedge clk) begin
      int pos;
      logic [7:0] got;
      if (!rstn) begin
         rx_active <= 1'b0;
         rx_cnt    <= 0;
      end else if (!rx_active) begin
         if (uart_tx === 1'b0) begin
            rx_active <= 1'b1;
            rx_cnt    <= 1;
         end
      end else begin
         pos = rx_cnt + 1;
         rx_cnt <= pos;
         if (pos == 6) begin
            check_eq("rx_start_bit", uart_tx, 1'b0);
         end else if ((pos > 6) && (pos < 96) && ((pos - 6) % DIV == 0)) begin
            rx_sh <= {uart_tx, rx_sh[7:1]};
         end else if (pos == 96) begin
            check_eq("rx_stop_bit", uart_tx, 1'b1);
            rx_active <= 1'b0;
            rx_frames <= rx_frames + 1;
            check_eq("rx_frame_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               got = exp_q.pop_front();
               check_eq("rx_byte", rx_sh, got);
            end
         end
      end
   end

   // Drive one write for one edge; queue the byte if it should be accepted.
   task automatic push_byte(input logic [7:0] b, input bit accept);
      wr_en   = 1'b1;
      wr_data = b;
      @(posedge clk);
      if (accept) exp_q.push_back(b);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((busy || rx_active) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_idle"}, busy | rx_active, 1'b0);
      check_eq({tag, "_queue_drained"}, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0;
      int sent;
      int cyc;
      bit saw_low;
      logic [7:0] b;
      logic [7:0] v55;

      rstn    = 1'b0;
      wr_en   = 1'b0;
      wr_data = 8'd0;
      repeat (3) @(negedge clk);
      check_eq("rst_uart_tx", uart_tx, 1'b1);
      check_eq("rst_full", full, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_level", level, 3'd0);
      check_eq("rst_overflow", overflow, 1'b0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // Test 1: single 0x55 frame, cycle-exact line and busy.
      v55 = 8'h55;
      push_byte(v55, 1'b1);
      check_eq("t1_level_e0", level, 3'd1);
      check_eq("t1_tx_e0", uart_tx, 1'b1);
      for (int k = 1; k <= 101; k++) begin
         logic exp_tx;
         @(negedge clk);
         if (k <= 10)      exp_tx = 1'b0;
         else if (k <= 90) exp_tx = v55[(k - 11) / 10];
         else              exp_tx = 1'b1;
         check_eq($sformatf("t1_tx_e%0d", k), uart_tx, exp_tx);
         check_eq($sformatf("t1_busy_e%0d", k), busy, (k <= 100) ? 1'b1 : 1'b0);
      end
      wait_idle("t1", 50);

      // Test 2: two back-to-back frames, zero gap.
      f0 = rx_frames;
      push_byte(8'hA3, 1'b1);
      check_eq("t2_level_e0", level, 3'd1);
      push_byte(8'h0F, 1'b1);
      check_eq("t2_level_e1", level, 3'd1);
      for (int k = 2; k <= 101; k++) begin
         @(negedge clk);
         if (k == 50)  check_eq("t2_level_e50", level, 3'd1);
         if (k == 100) check_eq("t2_stop_e100", uart_tx, 1'b1);
         if (k == 101) begin
            check_eq("t2_start_e101", uart_tx, 1'b0);
            check_eq("t2_level_e101", level, 3'd0);
         end
      end
      wait_idle("t2", 200);
      check_eq("t2_frames", rx_frames - f0, 2);

      // Test 3: six writes while idle; fifth fills, sixth is dropped.
      f0 = rx_frames;
      push_byte(8'h11, 1'b1);
      push_byte(8'h22, 1'b1);
      push_byte(8'h33, 1'b1);
      push_byte(8'h44, 1'b1);
      check_eq("t3_full_e3", full, 1'b0);
      push_byte(8'h55, 1'b1);
      check_eq("t3_full_e4", full, 1'b1);
      check_eq("t3_level_e4", level, 3'd4);
      check_eq("t3_ovf_e4", overflow, 1'b0);
      push_byte(8'h66, 1'b0);
      check_eq("t3_level_e5", level, 3'd4);
      check_eq("t3_ovf_e5", overflow, 1'b1);
      wait_idle("t3", 600);
      check_eq("t3_frames", rx_frames - f0, 5);
      check_eq("t3_ovf_sticky", overflow, 1'b1);

      // Test 4: reset at clock 47 of a frame with a byte still queued.
      f0 = rx_frames;
      push_byte(8'h00, 1'b1);
      push_byte(8'h00, 1'b1);
      repeat (46) @(negedge clk);
      check_eq("t4_tx_before_rst", uart_tx, 1'b0);
      check_eq("t4_level_before_rst", level, 3'd1);
      #2;
      rstn = 1'b0;
      #1;
      check_eq("t4_tx_async", uart_tx, 1'b1);
      check_eq("t4_level_async", level, 3'd0);
      check_eq("t4_ovf_async", overflow, 1'b0);
      check_eq("t4_busy_async", busy, 1'b0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      saw_low = 1'b0;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) saw_low = 1'b1;
      end
      check_eq("t4_no_residual", saw_low, 1'b0);
      check_eq("t4_busy_after", busy, 1'b0);
      check_eq("t4_frames", rx_frames - f0, 0);

      // Test 5: write while full in the same cycle as a pop is still dropped.
      f0 = rx_frames;
      push_byte(8'hC1, 1'b1);
      push_byte(8'hC2, 1'b1);
      push_byte(8'hC3, 1'b1);
      push_byte(8'hC4, 1'b1);
      push_byte(8'hC5, 1'b1);
      repeat (96) @(negedge clk);
      check_eq("t5_full_e100", full, 1'b1);
      check_eq("t5_ovf_e100", overflow, 1'b0);
      check_eq("t5_stop_e100", uart_tx, 1'b1);
      push_byte(8'hEE, 1'b0);
      check_eq("t5_level_e101", level, 3'd3);
      check_eq("t5_ovf_e101", overflow, 1'b1);
      check_eq("t5_start_e101", uart_tx, 1'b0);
      wait_idle("t5", 500);
      check_eq("t5_frames", rx_frames - f0, 5);

      // Test 6: 200 random bytes, writer throttled by full.
      do_reset();
      check_eq("t6_ovf_reset", overflow, 1'b0);
      f0   = rx_frames;
      sent = 0;
      cyc  = 0;
      while ((sent < 200) && (cyc < 40000)) begin
         if (!full && ($urandom_range(0, 3) != 0)) begin
            b = 8'($urandom_range(0, 255));
            wr_en   = 1'b1;
            wr_data = b;
            @(posedge clk);
            exp_q.push_back(b);
            sent++;
         end else begin
            wr_en = 1'b0;
            @(posedge clk);
         end
         @(negedge clk);
         wr_en = 1'b0;
         cyc++;
      end
      check_eq("t6_sent", sent, 200);
      wait_idle("t6", 1000);
      check_eq("t6_frames", rx_frames - f0, 200);
      check_eq("t6_ovf", overflow, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
